// File: rtl/game_pkg.sv
// Shared playfield geometry for the player, enemy and bullet blocks.
package game_pkg;

  localparam int COORD_W = 10;
  localparam int X_MIN   = 144;
  localparam int X_MAX   = 783;
  localparam int Y_MIN   = 31;
  localparam int Y_MAX   = 510;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    SHOT_SINGLE = 1'b0,
    SHOT_DOUBLE = 1'b1
  } shot_mode_e;

  // Clamp a signed spawn x so a bullet of width bw stays on the playfield.
  function automatic coord_t clamp_x(input logic signed [COORD_W+1:0] sx, input int bw);
    int lim;
    lim = X_MAX - bw;
    if (sx < X_MIN)    return coord_t'(X_MIN);
    else if (sx > lim) return coord_t'(lim);
    else               return coord_t'(sx);
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet: position, in-flight flag, upward motion and scan-pixel compare.
module bullet_slot
  import game_pkg::*;
#(
  parameter int STEP = 4,
  parameter int BW   = 2,
  parameter int BH   = 6
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   tick,
  input  logic   pause,
  input  logic   hit,
  input  logic   spawn,
  input  coord_t spawn_x,
  input  coord_t spawn_y,
  input  coord_t x,
  input  coord_t y,
  output logic   active,
  output logic   active_nxt,
  output logic   on
);

  coord_t bx, by, bx_nxt, by_nxt;

  // Next state: hit beats everything, then a spawn load, then motion.
  always_comb begin
    active_nxt = active;
    bx_nxt     = bx;
    by_nxt     = by;
    if (hit) begin
      active_nxt = 1'b0;
    end else if (spawn) begin
      active_nxt = 1'b1;
      bx_nxt     = spawn_x;
      by_nxt     = spawn_y;
    end else if (active && tick && !pause) begin
      if (by < coord_t'(Y_MIN + STEP)) active_nxt = 1'b0;
      else                             by_nxt     = by - coord_t'(STEP);
    end
  end

  // Slot state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      bx     <= '0;
      by     <= '0;
    end else begin
      active <= active_nxt;
      bx     <= bx_nxt;
      by     <= by_nxt;
    end
  end

  assign on = active
           && (x >= bx) && ({1'b0, x} < ({1'b0, bx} + (COORD_W+1)'(BW)))
           && (y >= by) && ({1'b0, y} < ({1'b0, by} + (COORD_W+1)'(BH)));

endmodule

// File: rtl/bullet_pool.sv
// Player bullet pool: fire cooldown, lowest-free-slot allocator and slot array.
module bullet_pool
  import game_pkg::*;
#(
  parameter int NUM_B    = 5,
  parameter int STEP     = 4,
  parameter int COOLDOWN = 8,
  parameter int BW       = 2,
  parameter int BH       = 6,
  parameter int SPREAD   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       pause,
  input  logic                       fire,
  input  logic                       mode,
  input  logic [COORD_W-1:0]         p_x,
  input  logic [COORD_W-1:0]         p_y,
  input  logic [NUM_B-1:0]           hit,
  input  logic [COORD_W-1:0]         x,
  input  logic [COORD_W-1:0]         y,
  output logic [NUM_B-1:0]           b_active,
  output logic [NUM_B-1:0]           b_on,
  output logic                       any_on,
  output logic [$clog2(NUM_B+1)-1:0] b_count
);

  localparam int CW = $clog2(NUM_B+1);

  logic [7:0]       cd;
  logic [NUM_B-1:0] free, first_oh, second_oh, spawn, active_nxt;
  logic             shot_ok, two_shot;
  logic [CW-1:0]    cnt_nxt;
  logic signed [COORD_W+1:0] px_s;
  coord_t           x_left, x_right, x_single, spawn_y;

  assign free    = ~b_active & ~hit;
  assign shot_ok = tick && !pause && fire && (cd == '0) && (|free);

  // Priority pick of the two lowest allocatable slots as one-hot masks.
  always_comb begin
    first_oh  = '0;
    second_oh = '0;
    for (int unsigned i = 0; i < NUM_B; i++) begin
      if (free[i]) begin
        if (first_oh == '0)       first_oh[i]  = 1'b1;
        else if (second_oh == '0) second_oh[i] = 1'b1;
      end
    end
  end

  // Double shot falls back to a centred single when only one slot is free.
  assign two_shot = shot_ok && (shot_mode_e'(mode) == SHOT_DOUBLE) && (|second_oh);
  assign spawn    = shot_ok ? (first_oh | (two_shot ? second_oh : '0)) : '0;

  assign px_s     = $signed({2'b00, p_x});
  assign x_left   = clamp_x(px_s - (COORD_W+2)'(SPREAD), BW);
  assign x_right  = clamp_x(px_s + (COORD_W+2)'(SPREAD), BW);
  assign x_single = clamp_x(px_s - (COORD_W+2)'(BW / 2), BW);
  assign spawn_y  = p_y - coord_t'(BH);

  // Shot cooldown: reload on an accepted shot, otherwise count down per tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd <= '0;
    end else if (tick && !pause) begin
      if (shot_ok)        cd <= 8'(COOLDOWN);
      else if (cd != '0)  cd <= cd - 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_B; i++) begin : g_slot
    coord_t slot_x;
    assign slot_x = two_shot ? (second_oh[i] ? x_right : x_left) : x_single;

    bullet_slot #(
      .STEP (STEP),
      .BW   (BW),
      .BH   (BH)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .pause      (pause),
      .hit        (hit[i]),
      .spawn      (spawn[i]),
      .spawn_x    (slot_x),
      .spawn_y    (spawn_y),
      .x          (x),
      .y          (y),
      .active     (b_active[i]),
      .active_nxt (active_nxt[i]),
      .on         (b_on[i])
    );
  end

  // Population count of the next active set, registered with the slots.
  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NUM_B; i++) cnt_nxt += CW'(active_nxt[i]);
  end

  // Active-slot count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) b_count <= '0;
    else      b_count <= cnt_nxt;
  end

  assign any_on = |b_on;

endmodule
